byte_mem_arbiter: RTL and testbench

Two-requester round-robin controller that shares a single byte-wide synchronous memory (active-low chip select, RW high = read, data out one edge after the command) between two clients. Each client issues a one-byte read or write with a req/gnt handshake. The arbiter sequences the memory's CS/RW/addr/din pins and returns read data with a one-cycle valid pulse. It sits between the CPU-side/DMA-side masters and the memory instance.

---
 rtl/byte_mem_arbiter_pkg.sv | 15 +
 rtl/byte_mem_arbiter_rr_arb2.sv | 29 ++
 rtl/byte_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_byte_mem_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_mem_arbiter_pkg.sv
// Shared types and pin-level constants for the byte-wide memory arbiter.
package byte_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic RD     = 1'b1;
  localparam logic WR     = 1'b0;
  localparam logic CS_ON  = 1'b0;
  localparam logic CS_OFF = 1'b1;

endpackage

// File: rtl/byte_mem_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker; prio names the client that wins a tie.
module rr_arb2 (
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_prio,
  output logic [1:0] o_grant,
  output logic       o_winner
);

  // Pick the single requester, or the prio client when both ask.
  always_comb begin
    o_grant  = 2'b00;
    o_winner = 1'b0;
    if (i_req0 && i_req1) begin
      o_winner = i_prio;
      o_grant  = i_prio ? 2'b10 : 2'b01;
    end else if (i_req1) begin
      o_winner = 1'b1;
      o_grant  = 2'b10;
    end else if (i_req0) begin
      o_winner = 1'b0;
      o_grant  = 2'b01;
    end else begin
      o_winner = 1'b0;
      o_grant  = 2'b00;
    end
  end

endmodule

// File: rtl/byte_mem_arbiter.sv
// Two-client round-robin front end for a single byte-wide synchronous memory.
// Each access is one CMD cycle with CS low; reads add one RESP cycle to capture data.
module byte_mem_arbiter
  import byte_mem_pkg::*;
#(
  parameter int ADDRWIDTH = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req0,
  input  logic                 i_req1,
  input  logic                 i_rw0,
  input  logic                 i_rw1,
  input  logic [ADDRWIDTH-1:0] i_addr0,
  input  logic [ADDRWIDTH-1:0] i_addr1,
  input  logic [7:0]           i_wdata0,
  input  logic [7:0]           i_wdata1,
  output logic                 o_gnt0,
  output logic                 o_gnt1,
  output logic                 o_rvalid0,
  output logic                 o_rvalid1,
  output logic [7:0]           o_rdata0,
  output logic [7:0]           o_rdata1,
  output logic                 o_busy,
  output logic                 o_mem_cs,
  output logic                 o_mem_rw,
  output logic [ADDRWIDTH-1:0] o_mem_addr,
  output logic [7:0]           o_mem_din,
  input  logic [7:0]           i_mem_dout
);

  state_t               r_state;
  logic                 r_prio;
  logic                 r_owner;
  logic                 r_busy;
  logic                 r_gnt0;
  logic                 r_gnt1;
  logic                 r_rvalid0;
  logic                 r_rvalid1;
  logic [7:0]           r_rdata0;
  logic [7:0]           r_rdata1;
  logic                 r_mem_cs;
  logic                 r_mem_rw;
  logic [ADDRWIDTH-1:0] r_mem_addr;
  logic [7:0]           r_mem_din;

  logic [1:0]           w_grant;
  logic                 w_winner;
  logic                 w_rw;
  logic [ADDRWIDTH-1:0] w_addr;
  logic [7:0]           w_wdata;

  rr_arb2 u_arb (
    .i_req0   (i_req0),
    .i_req1   (i_req1),
    .i_prio   (r_prio),
    .o_grant  (w_grant),
    .o_winner (w_winner)
  );

  // Route the winning client's command fields toward the memory pins.
  always_comb begin
    w_rw    = i_rw0;
    w_addr  = i_addr0;
    w_wdata = i_wdata0;
    if (w_winner) begin
      w_rw    = i_rw1;
      w_addr  = i_addr1;
      w_wdata = i_wdata1;
    end else begin
      w_rw    = i_rw0;
      w_addr  = i_addr0;
      w_wdata = i_wdata0;
    end
  end

  // Sequencer: requests are only looked at in IDLE, so clients may move on after gnt.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_prio     <= 1'b0;
      r_owner    <= 1'b0;
      r_busy     <= 1'b0;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_rdata0   <= 8'h00;
      r_rdata1   <= 8'h00;
      r_mem_cs   <= CS_OFF;
      r_mem_rw   <= RD;
      r_mem_addr <= {ADDRWIDTH{1'b0}};
      r_mem_din  <= 8'h00;
    end else begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant != 2'b00) begin
            r_mem_rw   <= w_rw;
            r_mem_addr <= w_addr;
            r_mem_din  <= w_wdata;
            r_mem_cs   <= CS_ON;
            r_gnt0     <= w_grant[0];
            r_gnt1     <= w_grant[1];
            r_prio     <= ~w_winner;
            r_owner    <= w_winner;
            r_busy     <= 1'b1;
            r_state    <= CMD;
          end
        end
        CMD: begin
          r_mem_cs <= CS_OFF;
          r_gnt0   <= 1'b0;
          r_gnt1   <= 1'b0;
          if (r_mem_rw == RD) begin
            r_busy  <= 1'b1;
            r_state <= RESP;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RESP: begin
          if (r_owner) begin
            r_rdata1  <= i_mem_dout;
            r_rvalid1 <= 1'b1;
          end else begin
            r_rdata0  <= i_mem_dout;
            r_rvalid0 <= 1'b1;
          end
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_mem_cs <= CS_OFF;
          r_gnt0   <= 1'b0;
          r_gnt1   <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign o_gnt0     = r_gnt0;
  assign o_gnt1     = r_gnt1;
  assign o_rvalid0  = r_rvalid0;
  assign o_rvalid1  = r_rvalid1;
  assign o_rdata0   = r_rdata0;
  assign o_rdata1   = r_rdata1;
  assign o_busy     = r_busy;
  assign o_mem_cs   = r_mem_cs;
  assign o_mem_rw   = r_mem_rw;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_din  = r_mem_din;

endmodule

// File: tb/tb_byte_mem_arbiter.sv
// Bench for byte_mem_arbiter: transaction-timeline reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized two-client traffic.
module tb_byte_mem_arbiter;
  import byte_mem_pkg::*;

  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req;
  logic [1:0]    rw;
  logic [AW-1:0] addr [2];
  logic [7:0]    wdata [2];
  logic          gnt0, gnt1, rv0, rv1, busy;
  logic [7:0]    rdata0, rdata1;
  logic          mem_cs, mem_rw;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din, mem_dout;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  byte_mem_arbiter #(.ADDRWIDTH(AW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req[0]), .i_req1(req[1]), .i_rw0(rw[0]), .i_rw1(rw[1]),
    .i_addr0(addr[0]), .i_addr1(addr[1]), .i_wdata0(wdata[0]), .i_wdata1(wdata[1]),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rv0), .o_rvalid1(rv1),
    .o_rdata0(rdata0), .o_rdata1(rdata1), .o_busy(busy),
    .o_mem_cs(mem_cs), .o_mem_rw(mem_rw), .o_mem_addr(mem_addr), .o_mem_din(mem_din),
    .i_mem_dout(mem_dout)
  );

  // Memory instance: data one edge after a read command, junk (stand-in for Z) otherwise.
  logic [7:0] mem_arr [8];
  logic [7:0] mem_q, junk;
  logic       mem_oe, mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 8; i++) mem_arr[i] <= 8'h00;
      mem_oe <= 1'b0;
    end else if (mem_cs == CS_ON) begin
      if (mem_rw == RD) begin
        mem_q  <= mem_arr[mem_addr];
        mem_oe <= 1'b1;
      end else begin
        mem_arr[mem_addr] <= mem_din;
        mem_oe <= 1'b0;
      end
    end else begin
      mem_oe <= 1'b0;
    end
  end
  always @(negedge clk) junk <= 8'($urandom);
  assign mem_dout = mem_oe ? mem_q : junk;

  // Reference model: each accepted request books a timeline of future events.
  logic [7:0]    ref_mem [8];
  int            m_e, m_free, m_rv_at, m_wr_at, m_rv_who;
  logic [7:0]    m_rv_data, m_wr_data;
  logic [AW-1:0] m_wr_addr;
  logic          m_prio;
  logic [1:0]    e_gnt, e_rv;
  logic [7:0]    e_rd [2];
  logic          e_busy, e_cs, e_rw;
  logic [AW-1:0] e_addr;
  logic [7:0]    e_din;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_free  = m_e;
    m_rv_at = -1;
    m_wr_at = -1;
    m_prio  = 1'b0;
    e_gnt   = 2'b00;
    e_rv    = 2'b00;
    e_rd[0] = 8'h00;
    e_rd[1] = 8'h00;
    e_busy  = 1'b0;
    e_cs    = 1'b1;
    e_rw    = 1'b1;
    e_addr  = '0;
    e_din   = 8'h00;
  endtask

  task automatic model_edge();
    int w;
    m_e++;
    e_gnt = 2'b00;
    e_rv  = 2'b00;
    e_cs  = 1'b1;
    if (m_e == m_wr_at) ref_mem[m_wr_addr] = m_wr_data;
    if (m_e == m_rv_at) begin
      e_rv[m_rv_who] = 1'b1;
      e_rd[m_rv_who] = m_rv_data;
    end
    if (m_e >= m_free && req != 2'b00) begin
      if (req == 2'b11) w = m_prio ? 1 : 0;
      else w = req[1] ? 1 : 0;
      m_prio   = (w == 0);
      e_gnt[w] = 1'b1;
      e_cs     = 1'b0;
      e_rw     = rw[w];
      e_addr   = addr[w];
      e_din    = wdata[w];
      if (rw[w] == WR) begin
        m_wr_at   = m_e + 1;
        m_wr_addr = addr[w];
        m_wr_data = wdata[w];
        m_free    = m_e + 2;
      end else begin
        m_rv_at   = m_e + 2;
        m_rv_who  = w;
        m_rv_data = ref_mem[addr[w]];
        m_free    = m_e + 3;
      end
    end
    e_busy = (m_e < m_free - 1);
  endtask

  // Per-cycle compare of every output against the model, on the inactive edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("gnt", 32'({gnt1, gnt0}), 32'(e_gnt));
      chk("rvalid", 32'({rv1, rv0}), 32'(e_rv));
      chk("rdata0", 32'(rdata0), 32'(e_rd[0]));
      chk("rdata1", 32'(rdata1), 32'(e_rd[1]));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("mem_cs", 32'(mem_cs), 32'(e_cs));
      chk("mem_rw", 32'(mem_rw), 32'(e_rw));
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("mem_din", 32'(mem_din), 32'(e_din));
      chk("xprop", 32'($isunknown({gnt0, gnt1, rv0, rv1, rdata0, rdata1, busy,
                                   mem_cs, mem_rw, mem_addr, mem_din})), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 10) begin
      tick();
      k++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  // Called at a negedge: asserts rst mid-cycle, checks the immediate effect, holds two edges.
  task automatic reset_mid();
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_cs", 32'(mem_cs), 32'd1);
    chk("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
    chk("rst_rvalid", 32'({rv1, rv0}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_op(input int c, input logic r, input logic [AW-1:0] a, input logic [7:0] d,
                       output logic [7:0] rd, output int lat);
    int k;
    bit got;
    rw[c] = r; addr[c] = a; wdata[c] = d; req[c] = 1'b1;
    got = 1'b0; k = 0;
    while (!got && k < 8) begin
      tick();
      k++;
      if (c == 0 ? gnt0 : gnt1) got = 1'b1;
    end
    req[c] = 1'b0;
    lat = k;
    chk("grant_seen", 32'(got), 32'd1);
    rd = 8'h00;
    if (r == RD) begin
      got = 1'b0; k = 0;
      while (!got && k < 4) begin
        tick();
        k++;
        if (c == 0 ? rv0 : rv1) begin
          got = 1'b1;
          rd  = (c == 0) ? rdata0 : rdata1;
        end
      end
      chk("rvalid_seen", 32'(got), 32'd1);
      chk("rvalid_delay", 32'(k), 32'd2);
    end else begin
      tick();
    end
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    int lat;
    int gw[$];
    int gt[$];
    req = 2'b00; rw = 2'b00; rst = 1'b0; mem_init = 1'b1; m_e = 0;
    for (int c = 0; c < 2; c++) begin addr[c] = '0; wdata[c] = 8'h00; end
    for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
    #1 rst = 1'b1;
    model_reset();
    #1 chk_en = 1'b1;
    tick();
    tick();
    mem_init = 1'b0;
    rst = 1'b0;
    chk("reset_cs", 32'(mem_cs), 32'd1);
    chk("reset_rdata0", 32'(rdata0), 32'd0);

    // Client 0 write then read of address 5.
    do_op(0, WR, 3'd5, 8'hA5, rd, lat);
    chk("wr_gnt_latency", 32'(lat), 32'd1);
    do_op(0, RD, 3'd5, 8'h00, rd, lat);
    chk("rd_a5", 32'(rd), 32'hA5);

    // Simultaneous writes right after reset: client 0 first, client 1 two cycles later.
    tick();
    reset_mid();
    rw = {WR, WR}; addr[0] = 3'd1; addr[1] = 3'd2; wdata[0] = 8'h11; wdata[1] = 8'h22;
    req = 2'b11;
    tick();
    chk("sim_first", 32'({gnt1, gnt0}), 32'h1);
    req[0] = 1'b0;
    tick();
    chk("sim_gap", 32'({gnt1, gnt0}), 32'h0);
    tick();
    chk("sim_second", 32'({gnt1, gnt0}), 32'h2);
    req[1] = 1'b0;
    wait_idle();
    do_op(0, RD, 3'd1, 8'h00, rd, lat);
    chk("rd_11", 32'(rd), 32'h11);
    do_op(1, RD, 3'd2, 8'h00, rd, lat);
    chk("rd_22", 32'(rd), 32'h22);

    // Both clients hold read requests: grants alternate every 3 cycles.
    rw = {RD, RD}; addr[0] = 3'($urandom); addr[1] = 3'($urandom);
    req = 2'b11;
    for (int t = 1; t <= 13; t++) begin
      tick();
      if (gnt0) begin gw.push_back(0); gt.push_back(t); addr[0] = 3'($urandom); end
      if (gnt1) begin gw.push_back(1); gt.push_back(t); addr[1] = 3'($urandom); end
    end
    req = 2'b00;
    wait_idle();
    chk("cont_count", 32'(gw.size()), 32'd5);
    for (int i = 0; i < gw.size(); i++) begin
      chk("cont_order", 32'(gw[i]), 32'(i % 2));
      if (i > 0) chk("cont_period", 32'(gt[i] - gt[i-1]), 32'd3);
    end

    // Reset while a write to address 3 sits in CMD: the write must not happen.
    rw[0] = WR; addr[0] = 3'd3; wdata[0] = 8'h77; req[0] = 1'b1;
    tick();
    chk("cmd_gnt", 32'(gnt0), 32'd1);
    req[0] = 1'b0;
    reset_mid();
    do_op(0, RD, 3'd3, 8'h00, rd, lat);
    chk("rd_aborted_wr", 32'(rd), 32'h00);

    // Reset while a read sits in RESP: no rvalid, rdata cleared, prio back to client 0.
    do_op(0, RD, 3'd5, 8'h00, rd, lat);
    chk("rd_a5_again", 32'(rd), 32'hA5);
    rw[0] = RD; addr[0] = 3'd1; req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    tick();
    reset_mid();
    chk("resp_rst_rdata0", 32'(rdata0), 32'h00);
    rw = {RD, RD}; addr[0] = 3'd2; addr[1] = 3'd5; req = 2'b11;
    tick();
    chk("prio_after_rst", 32'({gnt1, gnt0}), 32'h1);
    chk("resp_rst_no_rv", 32'({rv1, rv0}), 32'h0);
    req[0] = 1'b0;
    for (int k = 0; k < 6 && req[1]; k++) begin
      tick();
      if (gnt1) req[1] = 1'b0;
    end
    chk("second_client_served", 32'(req[1]), 32'd0);
    req = 2'b00;
    wait_idle();
    tick();

    // Randomized traffic, with one mid-run reset.
    for (int n = 0; n < 500; n++) begin
      if (n == 250) begin
        req = 2'b00;
        reset_mid();
      end
      for (int c = 0; c < 2; c++) begin
        if (req[c] && (c == 0 ? gnt0 : gnt1)) req[c] = 1'b0;
        if (!req[c] && $urandom_range(0, 9) < 5) begin
          rw[c]    = 1'($urandom);
          addr[c]  = 3'($urandom);
          wdata[c] = 8'($urandom);
          req[c]   = 1'b1;
        end
      end
      tick();
    end
    req = 2'b00;
    tick();
    wait_idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
